// File: rtl/wishbone_board_init.sv
// Wishbone master that builds a minesweeper board: clears the active area, drops
// LFSR-placed mines and bumps each mine's in-bounds neighbour counts via read-modify-write.
module wishbone_board_init #(
  parameter int unsigned BOARD_SIZE   = 16,
  parameter int unsigned MINE_BIT     = 7,
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [8:0]  mine_count_i,
  input  logic [15:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [8:0]  mines_placed_o,
  output logic        m_wr_cyc_o,
  output logic        m_wr_stb_o,
  output logic        m_wr_we_o,
  output logic [7:0]  m_wr_adr_o,
  output logic [7:0]  m_wr_dat_o,
  input  logic        m_wr_stall_i,
  input  logic        m_wr_ack_i,
  output logic        m_rd_cyc_o,
  output logic        m_rd_stb_o,
  output logic        m_rd_we_o,
  output logic [7:0]  m_rd_adr_o,
  input  logic        m_rd_stall_i,
  input  logic        m_rd_ack_i,
  input  logic [7:0]  m_rd_dat_i
);

  localparam logic [4:0] BsLim    = 5'(BOARD_SIZE);
  localparam logic [3:0] BsLast   = 4'(BOARD_SIZE - 1);
  localparam logic [8:0] MaxMines = 9'(BOARD_SIZE * BOARD_SIZE - 1);
  localparam logic [7:0] MineMask = 8'(1 << MINE_BIT);

  typedef enum logic [3:0] {
    StIdle, StClr, StPick, StRdCand, StWrMine, StNbSel, StNbRd, StNbWr, StDone
  } state_e;

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d;
  logic [3:0]  row_q, row_d, col_q, col_d;
  logic [7:0]  cand_q, cand_d, data_q, data_d;
  logic [2:0]  k_q, k_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  limit_q, limit_d, placed_q, placed_d;

  logic        wr_sel, rd_sel, bus_stall, bus_ack, bus_done;
  logic [15:0] lfsr_nxt;
  logic        cand_ok;
  logic [5:0]  nb_row, nb_col;
  logic        nb_in;
  logic [7:0]  nb_adr, wr_adr, wr_dat, rd_adr;
  state_e      fin_state;

  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign cand_ok  = ({1'b0, lfsr_nxt[7:4]} < BsLim) && ({1'b0, lfsr_nxt[3:0]} < BsLim);

  // Unsigned offsets: stepping below zero wraps to bit 5 set, which reads as out of bounds.
  always_comb begin
    nb_row = {2'b00, cand_q[7:4]};
    nb_col = {2'b00, cand_q[3:0]};
    unique case (k_q)
      3'd0, 3'd1, 3'd2: nb_row = nb_row - 6'd1;
      3'd5, 3'd6, 3'd7: nb_row = nb_row + 6'd1;
      default: ;
    endcase
    unique case (k_q)
      3'd0, 3'd3, 3'd5: nb_col = nb_col - 6'd1;
      3'd2, 3'd4, 3'd7: nb_col = nb_col + 6'd1;
      default: ;
    endcase
  end

  assign nb_in  = !nb_row[5] && !nb_col[5] && (nb_row[4:0] < BsLim) && (nb_col[4:0] < BsLim);
  assign nb_adr = {nb_row[3:0], nb_col[3:0]};

  assign wr_sel    = state_q inside {StClr, StWrMine, StNbWr};
  assign rd_sel    = state_q inside {StRdCand, StNbRd};
  assign bus_stall = wr_sel ? m_wr_stall_i : m_rd_stall_i;
  assign bus_ack   = wr_sel ? m_wr_ack_i : m_rd_ack_i;
  assign fin_state = (placed_q == limit_q) ? StDone : StPick;

  always_comb begin
    wr_adr = 8'h00;
    wr_dat = 8'h00;
    unique case (state_q)
      StClr:    wr_adr = {row_q, col_q};
      StWrMine: begin wr_adr = cand_q; wr_dat = data_q | MineMask; end
      StNbWr:   begin wr_adr = nb_adr; wr_dat = {data_q[7:4], data_q[3:0] + 4'd1}; end
      default: ;
    endcase
  end

  assign rd_adr = (state_q == StNbRd) ? nb_adr : cand_q;

  assign m_wr_cyc_o = cyc_q & wr_sel;
  assign m_wr_stb_o = stb_q & wr_sel;
  assign m_wr_we_o  = cyc_q & wr_sel;
  assign m_wr_adr_o = m_wr_cyc_o ? wr_adr : 8'h00;
  assign m_wr_dat_o = m_wr_cyc_o ? wr_dat : 8'h00;
  assign m_rd_cyc_o = cyc_q & rd_sel;
  assign m_rd_stb_o = stb_q & rd_sel;
  assign m_rd_we_o  = 1'b0;
  assign m_rd_adr_o = m_rd_cyc_o ? rd_adr : 8'h00;

  assign busy_o         = !(state_q inside {StIdle, StDone});
  assign done_o         = (state_q == StDone);
  assign mines_placed_o = placed_q;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    row_d    = row_q;
    col_d    = col_q;
    cand_d   = cand_q;
    data_d   = data_q;
    k_d      = k_q;
    lfsr_d   = lfsr_q;
    limit_d  = limit_q;
    placed_d = placed_q;
    bus_done = 1'b0;

    // A bus state launches its transaction from an idle cycle, which also gives the
    // mandatory gap between back-to-back cycles on different ports.
    if (wr_sel || rd_sel) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        stb_d = 1'b1;
      end else begin
        if (stb_q && !bus_stall) stb_d = 1'b0;
        if (bus_ack) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          bus_done = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StClr;
          row_d    = 4'd0;
          col_d    = 4'd0;
          limit_d  = (mine_count_i > MaxMines) ? MaxMines : mine_count_i;
          lfsr_d   = (seed_i == 16'h0000) ? LFSR_DEFAULT : seed_i;
          placed_d = 9'd0;
        end
      end
      StClr: begin
        if (bus_done) begin
          if (col_q == BsLast) begin
            col_d = 4'd0;
            if (row_q == BsLast) state_d = (limit_q == 9'd0) ? StDone : StPick;
            else                 row_d   = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      StPick: begin
        lfsr_d = lfsr_nxt;
        cand_d = lfsr_nxt[7:0];
        if (cand_ok) state_d = StRdCand;
      end
      StRdCand: begin
        if (bus_done) begin
          if (m_rd_dat_i[MINE_BIT]) begin
            state_d = StPick;
          end else begin
            data_d  = m_rd_dat_i;
            state_d = StWrMine;
          end
        end
      end
      StWrMine: begin
        if (bus_done) begin
          placed_d = placed_q + 9'd1;
          k_d      = 3'd0;
          state_d  = StNbSel;
        end
      end
      StNbSel: begin
        if (nb_in)             state_d = StNbRd;
        else if (k_q == 3'd7)  state_d = fin_state;
        else                   k_d     = k_q + 3'd1;
      end
      StNbRd: begin
        if (bus_done) begin
          data_d  = m_rd_dat_i;
          state_d = StNbWr;
        end
      end
      StNbWr: begin
        if (bus_done) begin
          if (k_q == 3'd7) begin
            state_d = fin_state;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = StNbSel;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      cand_q   <= 8'h00;
      data_q   <= 8'h00;
      k_q      <= 3'd0;
      lfsr_q   <= LFSR_DEFAULT;
      limit_q  <= 9'd0;
      placed_q <= 9'd0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cand_q   <= cand_d;
      data_q   <= data_d;
      k_q      <= k_d;
      lfsr_q   <= lfsr_d;
      limit_q  <= limit_d;
      placed_q <= placed_d;
    end
  end

endmodule

// File: tb/tb_wishbone_board_init.sv
// Bench for wishbone_board_init: three instances (16x16, 8x8, 4x4) on a shared clock, each
// with a stalling memory model, a transaction scoreboard and a board-level reference model.
module tb_wishbone_board_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cycle    = 0;
  bit fin [3];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_i
    localparam int BS = (g == 0) ? 16 : (g == 1) ? 8 : 4;
    localparam int G  = g;

    logic        rst = 1'b1, start = 1'b0;
    logic [8:0]  mine_count = '0;
    logic [15:0] seed = '0;
    logic        busy, done;
    logic [8:0]  placed;
    logic        wr_cyc, wr_stb, wr_we, wr_stall = 1'b0, wr_ack = 1'b0;
    logic [7:0]  wr_adr, wr_dat;
    logic        rd_cyc, rd_stb, rd_we, rd_stall = 1'b0, rd_ack = 1'b0;
    logic [7:0]  rd_adr, rd_dat = 8'h00;

    wishbone_board_init #(.BOARD_SIZE(BS)) u_dut (
      .clk(clk), .rst(rst), .start_i(start), .mine_count_i(mine_count), .seed_i(seed),
      .busy_o(busy), .done_o(done), .mines_placed_o(placed),
      .m_wr_cyc_o(wr_cyc), .m_wr_stb_o(wr_stb), .m_wr_we_o(wr_we), .m_wr_adr_o(wr_adr),
      .m_wr_dat_o(wr_dat), .m_wr_stall_i(wr_stall), .m_wr_ack_i(wr_ack),
      .m_rd_cyc_o(rd_cyc), .m_rd_stb_o(rd_stb), .m_rd_we_o(rd_we), .m_rd_adr_o(rd_adr),
      .m_rd_stall_i(rd_stall), .m_rd_ack_i(rd_ack), .m_rd_dat_i(rd_dat)
    );

    logic [7:0]  mem [256];
    logic [7:0]  exp_board [256];
    logic [7:0]  sv [256];
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [15:0] e_wr;
    logic [7:0]  e_rd;
    int          exp_placed, wr_count, rd_count, last_ack, done_cyc, grant;
    bit          rnd_stall, pend_wr, pend_rd, held_wr, held_rd;
    logic [7:0]  pa_wr, pd_wr, pa_rd, ha_wr, hd_wr, ha_rd;

    // Memory slave: grant is registered, so the first request after a port switch stalls.
    always @(negedge clk) begin
      if (rst) begin
        pend_wr = 0; pend_rd = 0; held_wr = 0; held_rd = 0;
        wr_ack = 0; rd_ack = 0; wr_stall = 0; rd_stall = 0; rd_dat = 8'h00; grant = 0;
      end else begin
        wr_ack = 0; rd_ack = 0; rd_dat = 8'h00;
        check($sformatf("g%0d cyc_exclusive", G), 32'(wr_cyc & rd_cyc), 0);
        if (pend_wr) begin
          pend_wr = 0;
          check($sformatf("g%0d wr_expected", G), 32'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) begin
            e_wr = exp_wr.pop_front();
            check($sformatf("g%0d wr_txn", G), {16'h0, pa_wr, pd_wr}, {16'h0, e_wr});
          end
          mem[pa_wr] = pd_wr; wr_ack = 1; wr_count++; last_ack = cycle;
        end
        if (pend_rd) begin
          pend_rd = 0;
          check($sformatf("g%0d rd_expected", G), 32'(exp_rd.size() > 0), 1);
          if (exp_rd.size() > 0) begin
            e_rd = exp_rd.pop_front();
            check($sformatf("g%0d rd_adr", G), 32'(pa_rd), 32'(e_rd));
          end
          rd_dat = mem[pa_rd]; rd_ack = 1; rd_count++; last_ack = cycle;
        end
        if (wr_stb) begin
          if (held_wr) check($sformatf("g%0d wr_hold", G), {wr_adr, wr_dat}, {ha_wr, hd_wr});
          check($sformatf("g%0d wr_we", G), 32'(wr_we & wr_cyc), 1);
          wr_stall = (grant != 0) || (rnd_stall && $urandom_range(3) == 0);
          grant = 0;
          if (!wr_stall) begin pend_wr = 1; pa_wr = wr_adr; pd_wr = wr_dat; held_wr = 0; end
          else begin held_wr = 1; ha_wr = wr_adr; hd_wr = wr_dat; end
        end else begin
          wr_stall = 0; held_wr = 0;
        end
        if (rd_stb) begin
          if (held_rd) check($sformatf("g%0d rd_hold", G), 32'(rd_adr), 32'(ha_rd));
          check($sformatf("g%0d rd_we", G), 32'(rd_we | !rd_cyc), 0);
          rd_stall = (grant != 1) || (rnd_stall && $urandom_range(3) == 0);
          grant = 1;
          if (!rd_stall) begin pend_rd = 1; pa_rd = rd_adr; held_rd = 0; end
          else begin held_rd = 1; ha_rd = rd_adr; end
        end else begin
          rd_stall = 0; held_rd = 0;
        end
      end
    end

    // Reference: expected transaction stream plus a board derived from the mine set alone.
    task automatic build_model(input int mc, input logic [15:0] sd);
      logic [7:0]  b [256];
      bit          mine [256];
      logic [15:0] l;
      int lim, np, r, c, a, nr, nc, cnt;
      exp_wr.delete(); exp_rd.delete();
      lim = (mc < BS * BS - 1) ? mc : BS * BS - 1;
      for (int i = 0; i < 256; i++) begin b[i] = 8'h00; mine[i] = 0; end
      for (int rr = 0; rr < BS; rr++)
        for (int cc = 0; cc < BS; cc++) exp_wr.push_back({8'(rr * 16 + cc), 8'h00});
      l = (sd == 16'h0) ? 16'hACE1 : sd;
      np = 0;
      while (np < lim) begin
        l = {l[14:0], ^(l & 16'hB400)};
        r = int'(l[7:4]); c = int'(l[3:0]);
        if (r >= BS || c >= BS) continue;
        a = r * 16 + c;
        exp_rd.push_back(8'(a));
        if (mine[a]) continue;
        mine[a] = 1; b[a] = b[a] | 8'h80; np++;
        exp_wr.push_back({8'(a), b[a]});
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            nr = r + dr; nc = c + dc;
            if ((dr == 0 && dc == 0) || nr < 0 || nc < 0 || nr >= BS || nc >= BS) continue;
            a = nr * 16 + nc;
            exp_rd.push_back(8'(a));
            b[a] = {b[a][7:4], b[a][3:0] + 4'd1};
            exp_wr.push_back({8'(a), b[a]});
          end
      end
      exp_placed = np;
      for (int i = 0; i < 256; i++) exp_board[i] = mem[i];
      for (int rr = 0; rr < BS; rr++)
        for (int cc = 0; cc < BS; cc++) begin
          cnt = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              nr = rr + dr; nc = cc + dc;
              if (!(dr == 0 && dc == 0) && nr >= 0 && nc >= 0 && nr < BS && nc < BS)
                if (mine[nr * 16 + nc]) cnt++;
            end
          exp_board[rr * 16 + cc] = {mine[rr * 16 + cc], 3'b000, 4'(cnt)};
        end
    endtask

    task automatic kick(input int mc, input logic [15:0] sd);
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      build_model(mc, sd);
      wr_count = 0; rd_count = 0;
      @(negedge clk);
      mine_count = 9'(mc); seed = sd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check($sformatf("g%0d busy_after_start", G), 32'(busy), 1);
    endtask

    task automatic run_build(input int mc, input logic [15:0] sd, input bit poke, input string tag);
      int t = 0;
      kick(mc, sd);
      if (poke) begin
        repeat (30) @(negedge clk);
        start = 1'b1; mine_count = 9'd3; seed = 16'h1234;
        @(negedge clk);
        start = 1'b0;
      end
      while (done !== 1'b1 && t < 40000) begin @(negedge clk); t++; end
      done_cyc = cycle;
      check($sformatf("g%0d %s done_seen", G, tag), 32'(done), 1);
      check($sformatf("g%0d %s busy_in_done", G, tag), 32'(busy), 0);
      check($sformatf("g%0d %s mines_placed", G, tag), 32'(placed), 32'(exp_placed));
      check($sformatf("g%0d %s wr_left", G, tag), exp_wr.size(), 0);
      check($sformatf("g%0d %s rd_left", G, tag), exp_rd.size(), 0);
      @(negedge clk);
      check($sformatf("g%0d %s done_pulse", G, tag), 32'({busy, done}), 0);
      check($sformatf("g%0d %s placed_hold", G, tag), 32'(placed), 32'(exp_placed));
      for (int i = 0; i < 256; i++)
        check($sformatf("g%0d %s cell %02h", G, tag, i), 32'(mem[i]), 32'(exp_board[i]));
    endtask

    task automatic reset_mid(input int mc, input logic [15:0] sd);
      int t = 0;
      kick(mc, sd);
      while (!(wr_count > BS * BS && rd_stb === 1'b1) && t < 20000) begin
        @(negedge clk); t++;
      end
      check($sformatf("g%0d nb_rd_reached", G), 32'(t < 20000), 1);
      #1 rst = 1'b1;
      @(negedge clk);
      check($sformatf("g%0d midrst_ctrl", G),
            {wr_cyc, wr_stb, wr_we, rd_cyc, rd_stb, rd_we, busy, done, placed}, 0);
      exp_wr.delete(); exp_rd.delete();
      rst = 1'b0;
      @(negedge clk);
    endtask

    task automatic reset_seq();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check($sformatf("g%0d rst_ctrl", G),
            {wr_cyc, wr_stb, wr_we, rd_cyc, rd_stb, rd_we, busy, done, placed}, 0);
      check($sformatf("g%0d rst_data", G), {wr_adr, wr_dat, rd_adr}, 0);
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("g%0d idle_ctrl", G),
            {wr_cyc, wr_stb, wr_we, rd_cyc, rd_stb, rd_we, busy, done, placed}, 0);
    endtask

    if (g == 0) begin : gen_t
      initial begin
        logic [15:0] s;
        reset_seq();
        rnd_stall = 0;
        run_build(0, 16'h0001, 0, "clear");
        check("g0 clear done_latency", done_cyc - last_ack, 1);
        check("g0 clear rd_count", rd_count, 0);
        check("g0 clear wr_count", wr_count, 256);
        run_build(1, 16'h0100, 0, "one_mine");
        check("g0 one_mine cell00", 32'(mem[8'h00]), 32'h80);
        check("g0 one_mine cell01", 32'(mem[8'h01]), 32'h01);
        check("g0 one_mine cell10", 32'(mem[8'h10]), 32'h01);
        check("g0 one_mine cell11", 32'(mem[8'h11]), 32'h01);
        check("g0 one_mine wr_count", wr_count, 260);
        check("g0 one_mine rd_count", rd_count, 4);
        rnd_stall = 1;
        run_build(20, 16'($urandom_range(1, 65535)), 1, "stall_poke");
        s = 16'($urandom_range(1, 65535));
        reset_mid(5, s);
        run_build(5, s, 0, "after_reset");
        fin[0] = 1;
      end
    end else if (g == 1) begin : gen_t
      initial begin
        logic [15:0] s;
        int nm;
        reset_seq();
        s = 16'($urandom_range(1, 65535));
        rnd_stall = 0;
        run_build(10, s, 0, "nostall");
        for (int i = 0; i < 256; i++) sv[i] = mem[i];
        nm = 0;
        for (int i = 0; i < 256; i++) if (i[7:4] < 8 && i[3:0] < 8 && mem[i][7]) nm++;
        check("g1 mine_cells", nm, 10);
        rnd_stall = 1;
        run_build(10, s, 0, "stall");
        for (int i = 0; i < 256; i++)
          if (i[7:4] < 8 && i[3:0] < 8)
            check($sformatf("g1 stall_vs_nostall %02h", i), 32'(mem[i]), 32'(sv[i]));
        reset_mid(10, s);
        run_build(10, 16'h0000, 0, "seed0_after_reset");
        fin[1] = 1;
      end
    end else begin : gen_t
      initial begin
        int nm;
        reset_seq();
        rnd_stall = 1;
        run_build(300, 16'($urandom_range(1, 65535)), 0, "clamp");
        check("g2 clamp placed", 32'(placed), 15);
        nm = 0;
        for (int i = 0; i < 256; i++) if (i[7:4] < 4 && i[3:0] < 4 && !mem[i][7]) nm++;
        check("g2 clamp non_mine_cells", nm, 1);
        fin[2] = 1;
      end
    end
  end

  initial begin
    int t = 0;
    while (!(fin[0] && fin[1] && fin[2]) && t < 90000) begin @(negedge clk); t++; end
    if (t >= 90000) check("global_timeout", 32'(t), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
